// File: rtl/regdump_ctrl.sv
// Debug register-dump controller: counts run cycles, halts the CPU on request
// or cycle limit, then streams every register-file entry over a valid/ready port.
module regdump_ctrl #(
  parameter int XLEN        = 64,
  parameter int NREGS       = 32,
  parameter int AW          = 5,
  parameter int CYCLE_LIMIT = 500
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run_en,
  input  logic            dump_req,
  output logic            cpu_stall,
  output logic [AW-1:0]   rf_raddr,
  input  logic [XLEN-1:0] rf_rdata,
  output logic            dump_valid,
  input  logic            dump_ready,
  output logic [AW-1:0]   dump_idx,
  output logic [XLEN-1:0] dump_data,
  output logic            dump_last,
  output logic [31:0]     cycle_count,
  output logic            done
);

  // state | meaning
  // RUN   | CPU running, cycle counter active, waiting for a trigger
  // HALT  | CPU frozen for one cycle so an in-flight register write retires
  // READ  | debug read port addressed with the current index, word captured
  // SEND  | captured word offered to the consumer until accepted
  // DONE  | all entries sent, CPU held frozen until reset

  if (NREGS < 2 || (1 << AW) < NREGS) begin : g_param_check
    $error("regdump_ctrl: NREGS must be >= 2 and fit in AW bits");
  end

  typedef enum logic [2:0] {
    S_RUN  = 3'd0,
    S_HALT = 3'd1,
    S_READ = 3'd2,
    S_SEND = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [AW-1:0] LAST_IDX  = AW'(NREGS - 1);
  localparam logic [31:0]   LIMIT     = 32'(CYCLE_LIMIT);
  localparam logic [31:0]   COUNT_MAX = '1;

  state_t          state, state_nxt;
  logic [AW-1:0]   idx, idx_nxt;
  logic [31:0]     count_nxt;
  logic [AW-1:0]   dump_idx_nxt;
  logic [XLEN-1:0] dump_data_nxt;
  logic            limit_hit;

  assign limit_hit = (CYCLE_LIMIT != 0) && (cycle_count == LIMIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_RUN;
      idx         <= '0;
      cycle_count <= '0;
      dump_idx    <= '0;
      dump_data   <= '0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      cycle_count <= count_nxt;
      dump_idx    <= dump_idx_nxt;
      dump_data   <= dump_data_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    count_nxt     = cycle_count;
    dump_idx_nxt  = dump_idx;
    dump_data_nxt = dump_data;
    cpu_stall     = 1'b1;
    rf_raddr      = '0;
    dump_valid    = 1'b0;
    dump_last     = 1'b0;
    done          = 1'b0;

    case (state)
      S_RUN: begin
        cpu_stall = 1'b0;
        // The trigger cycle does not count, so the count stays at the trigger value.
        if (dump_req || limit_hit) begin
          state_nxt = S_HALT;
        end else if (run_en && (cycle_count != COUNT_MAX)) begin
          count_nxt = cycle_count + 32'd1;
        end
      end

      S_HALT: begin
        idx_nxt   = '0;
        state_nxt = S_READ;
      end

      S_READ: begin
        rf_raddr      = idx;
        dump_data_nxt = rf_rdata;
        dump_idx_nxt  = idx;
        state_nxt     = S_SEND;
      end

      S_SEND: begin
        dump_valid = 1'b1;
        dump_last  = (dump_idx == LAST_IDX);
        if (dump_ready) begin
          if (idx == LAST_IDX) begin
            state_nxt = S_DONE;
          end else begin
            idx_nxt   = idx + 1'b1;
            state_nxt = S_READ;
          end
        end
      end

      S_DONE: begin
        done = 1'b1;
      end

      default: begin
        state_nxt = S_RUN;
      end
    endcase
  end

endmodule
